// File: rtl/seg7_pkg.sv
// Shared types for the 4-digit 7-segment scan controller.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    GUARD
  } state_t;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/seg7_prescaler.sv
// Loadable down-counter; tc is high while the count sits at zero.
// A load of N gives N+1 cycles until tc releases the next transition.
module seg7_prescaler #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit scan with guard gaps and frame-aligned double-buffered loads.
// Outputs lag the FSM by one cycle; load_ready stays low from capture until commit.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int GUARD_CYC = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  blank_mask,
  input  logic        lz_en,
  output logic [3:0]  digit,
  output logic [3:0]  com,
  output logic        blank,
  output logic        frame_tick
);
  import seg7_pkg::*;

  localparam int MAX_CYC = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);

  state_t                     state, state_nxt;
  logic [1:0]                 idx, idx_nxt;
  logic                       psc_load, psc_tc, frame_end;
  logic [CNT_W-1:0]           psc_val;
  nibble_t [NUM_DIGITS-1:0]   active, shadow;
  logic                       pending, commit, xfer, lz;
  logic [NUM_DIGITS-1:0]      tail_zero;

  seg7_prescaler #(.W(CNT_W)) u_psc (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (psc_load),
    .load_val (psc_val),
    .tc       (psc_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Every state entry (including SHOW->SHOW without guard) reloads the prescaler.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    psc_load  = 1'b0;
    frame_end = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
      psc_load  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SHOW;
          idx_nxt   = '0;
          psc_load  = 1'b1;
        end
        SHOW: begin
          if (psc_tc) begin
            psc_load = 1'b1;
            if (GUARD_CYC == 0) begin
              idx_nxt   = idx + 2'd1;
              frame_end = (idx == 2'd3);
            end else begin
              state_nxt = GUARD;
            end
          end
        end
        GUARD: begin
          if (psc_tc) begin
            state_nxt = SHOW;
            idx_nxt   = idx + 2'd1;
            psc_load  = 1'b1;
            frame_end = (idx == 2'd3);
          end
        end
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          psc_load  = 1'b1;
        end
      endcase
    end
  end

  assign psc_val = (state_nxt == SHOW)  ? SHOW_LD  :
                   (state_nxt == GUARD) ? GUARD_LD : '0;

  assign load_ready = ~pending;
  assign xfer       = load_valid & load_ready;
  // With the scan stopped there is no frame boundary to wait for.
  assign commit     = pending & (frame_end | ~en);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (commit) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (xfer) begin
      shadow  <= load_data;
      pending <= 1'b1;
    end
  end

  always_comb begin
    tail_zero[NUM_DIGITS-1] = (active[NUM_DIGITS-1] == 4'h0);
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      tail_zero[k] = tail_zero[k+1] & (active[k] == 4'h0);
    end
  end

  assign lz = lz_en & (idx != 2'd0) & tail_zero[idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      com        <= '0;
      digit      <= '0;
      blank      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (state == SHOW) begin
        com   <= 4'b0001 << idx;
        digit <= active[idx];
        blank <= blank_mask[idx] | lz;
      end else begin
        com   <= '0;
        blank <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Multiplexed scan controller for a 4-digit common-electrode 7-segment display. It holds a 16-bit, 4-nibble display value and time-multiplexes the digits onto one shared segment decoder. Each scan slot drives the active digit's nibble on `digit` and raises the matching one-hot `com` line. It sits between the register/host side and the existing combinational segment decoder, which consumes `digit` and produces segments `a`–`g`. New values are double-buffered and committed only at frame boundaries, so the display never tears mid-frame.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles each digit is shown (≥2).
- `GUARD_CYC`, default 8: blank cycles between digits for anti-ghosting (0 disables the guard).

Ports:
- `clk` in 1: single system clock. All logic is rising-edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `en` in 1: scan enable. When low, the display is dark and loads commit immediately.
- `load_valid` in 1: host offers a new display value.
- `load_ready` out 1: the controller can accept a value.
- `load_data` in 16: nibble k (`[4k+3:4k]`) is shown on digit k.
- `blank_mask` in 4: bit k=1 forces digit k dark. Sampled live.
- `lz_en` in 1: leading-zero suppression. Sampled live.
- `digit` out 4: nibble sent to the segment decoder.
- `com` out 4: one-hot, active-high digit select; `4'b0001` selects digit 0.
- `blank` out 1: when 1, the decoder output must be masked.
- `frame_tick` out 1: one-cycle pulse at the end of each full 4-digit frame.

## Operation
- FSM states:
  - IDLE: `com`=0, `blank`=1.
  - SHOW: `com`=onehot(idx), `digit`=active[idx].
  - GUARD: `com`=0, `blank`=1, `digit` holds its last value.
- FSM transitions:
  - IDLE→SHOW with idx=0 when `en`=1.
  - SHOW→GUARD after `SHOW` has lasted `SCAN_DIV` cycles. If `GUARD_CYC`=0, go straight to SHOW of the next idx.
  - GUARD→SHOW(idx+1 mod 4) after `GUARD_CYC` cycles.
  - Any state→IDLE when `en`=0, with idx and the prescaler cleared.
- Prescaler: counts 0..`SCAN_DIV`-1 in SHOW and 0..`GUARD_CYC`-1 in GUARD. It resets on every state entry and wraps with no drift.
- Frame end: the transition that leaves idx=3 (out of GUARD, or out of SHOW when there is no guard).
  - `frame_tick` pulses for 1 cycle.
  - A pending shadow value is copied to the active register.
- Load handshake:
  - Transfer occurs when `load_valid`&&`load_ready` → shadow←`load_data`, pending←1, and `load_ready` drops the next cycle.
  - `load_ready` returns to 1 on the cycle after the commit.
  - When `en`=0, a pending value commits on the cycle after capture.
  - Only one value is outstanding at a time. `load_valid` while `load_ready`=0 is ignored; the host holds it.
- Blanking in SHOW: `blank`=`blank_mask[idx]` OR LZ(idx).
- LZ(idx): true when `lz_en`=1, idx≥1, and all active nibbles from idx up to 3 are 0. Digit 0 is never suppressed.

## Timing
- Reset values:
  - `com`=0, `digit`=0, `blank`=1, `frame_tick`=0, `load_ready`=1.
  - Active and shadow registers = 0, pending = 0, idx = 0.
  - State = IDLE.
- All outputs are registered. `com`, `digit` and `blank` change 1 cycle after the state transition.
- Frame period = 4×(`SCAN_DIV`+`GUARD_CYC`) cycles.
- Between `com` deasserting and the next `com` asserting there are exactly `GUARD_CYC` cycles with `com`=0. The outgoing and incoming one-hot values never overlap.
- A commit and a new `load_valid` in the same cycle: the commit wins, and the new value is accepted no earlier than the next cycle.
- `rst_n` low mid-frame returns everything to its reset values on the next edge, including any pending shadow value, which is discarded.

## Structure
- Package `seg7_pkg`: state enum {IDLE, SHOW, GUARD}, `NUM_DIGITS`=4, and the nibble type.
- Sub-module `seg7_prescaler`: a loadable down-counter with a terminal-count output, reused for the SHOW and GUARD intervals.
- The segment decoder is not instantiated here. The top level connects `digit` to it and masks its output with `blank`.

## Test plan
Tests use `SCAN_DIV`=4 and `GUARD_CYC`=1 unless noted.
- Reset, then `en`=1 → `com` sequence 0001,0000,0010,0000,0100,0000,1000,0000, with 4 cycles per SHOW and 1 per GUARD; `frame_tick` every 20 cycles.
- Load 16'h1234 while scanning mid-frame → `load_ready`=0 until the frame end. The old value stays on screen for the rest of the frame. The next frame shows `digit`=4,3,2,1 on idx 0..3.
- `lz_en`=1, value 16'h0050 → idx3 and idx2 have `blank`=1, while idx1 (5) and idx0 (0) are shown. Value 16'h0000 → only idx0 is shown.
- `blank_mask`=4'b0100 → `blank`=1 only during idx2's SHOW. `GUARD_CYC`=0 → `com` goes straight from 0001 to 0010, frame of 16 cycles.
- `en`=0 with a pending load → `com`=0, and the value commits and `load_ready`=1 within 2 cycles. Then `en`=1 → idx0 shows the new nibble.
- `rst_n`=0 during idx2 SHOW with a pending load → next edge all reset values appear. After release, the old shadow value is never displayed.
